tlb_assoc_asid: RTL and testbench



---
 rtl/tlb_assoc_asid.sv | 234 +++++++++++++++++++++++
 tb/tb_tlb_assoc_asid.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tlb_assoc_asid.sv
// Fully-associative Sv39 TLB with ASID tags, 2M/1G superpages, selective sfence.vma flush
// and round-robin refill. Misses go to the page-table walker; dirty writes go through the BIU.
module tlb_assoc_asid #(
  parameter int ENTRIES = 8,
  parameter int ASID_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vm_on,
  input  logic              mxr,
  input  logic              sum,
  input  logic [3:0]        priv,
  input  logic [ASID_W-1:0] asid,
  input  logic              read,
  input  logic              write,
  input  logic              execute,
  input  logic [63:0]       addr_va,
  output logic [63:0]       addr_pa,
  output logic              pte_c,
  output logic              tlb_ready,
  output logic              load_page_fault,
  output logic              store_page_fault,
  output logic              ins_page_fault,
  output logic              ptw_req,
  output logic [63:0]       ptw_va,
  input  logic              ptw_ack,
  input  logic              ptw_fault,
  input  logic [63:0]       ptw_pte,
  input  logic [63:0]       ptw_pte_pa,
  input  logic [1:0]        ptw_level,
  output logic              wt_req,
  output logic [63:0]       wt_pte,
  output logic [63:0]       wt_pte_pa,
  input  logic              wt_ack,
  input  logic              flush,
  input  logic              flush_va_en,
  input  logic              flush_asid_en,
  input  logic [63:0]       flush_va,
  input  logic [ASID_W-1:0] flush_asid,
  output logic [1:0]        state_dbg
);

  localparam int IW = $clog2(ENTRIES);

  typedef enum logic [1:0] {S_IDLE, S_WALK, S_WT, S_FAULT} state_t;

  state_t state_q, state_d;
  logic   drop;
  logic [IW-1:0] rr_ptr, wt_idx;

  logic [ENTRIES-1:0] e_valid;
  logic [26:0]        e_vpn    [ENTRIES];
  logic [ASID_W-1:0]  e_asid   [ENTRIES];
  logic [1:0]         e_lvl    [ENTRIES];
  logic [43:0]        e_ppn    [ENTRIES];
  logic [63:0]        e_pte    [ENTRIES];
  logic [63:0]        e_pte_pa [ENTRIES];

  logic               translate, access;
  logic [26:0]        va_vpn, flush_vpn;
  logic               hit, perm_ok, need_wt, misaligned;
  logic [IW-1:0]      hit_idx, free_idx, fill_idx;
  logic               free_found, fill_en, wt_done;
  logic [43:0]        ppn_eff;
  logic [63:0]        hit_pa;
  logic [ENTRIES-1:0] flush_hit;
  logic               unused_ok;

  // Superpage leaves ignore the low VPN slices they cover.
  function automatic logic vpn_match(input logic [26:0] a, input logic [26:0] b,
                                     input logic [1:0] lvl);
    logic [26:0] m;
    m = '1;
    if (lvl != 2'd0) m[8:0] = '0;
    if (lvl[1]) m[17:0] = '0;
    return ((a ^ b) & m) == 27'd0;
  endfunction

  assign translate = vm_on & ~priv[3];
  assign access    = read | write | execute;
  assign va_vpn    = addr_va[38:12];
  assign flush_vpn = flush_va[38:12];
  assign ptw_va    = addr_va;
  assign state_dbg = state_q;
  assign unused_ok = ^{priv[2], flush_va[63:39], flush_va[11:0]};

  // Descending scan so the lowest matching index is the one left standing.
  always_comb begin
    hit        = 1'b0;
    hit_idx    = '0;
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (e_valid[i] && vpn_match(e_vpn[i], va_vpn, e_lvl[i]) &&
          (e_pte[i][5] || e_asid[i] == asid)) begin
        hit     = 1'b1;
        hit_idx = IW'(i);
      end
      if (!e_valid[i]) begin
        free_found = 1'b1;
        free_idx   = IW'(i);
      end
    end
  end

  assign fill_idx = free_found ? free_idx : rr_ptr;

  always_comb begin
    ppn_eff = e_ppn[hit_idx];
    if (e_lvl[hit_idx] != 2'd0) ppn_eff[8:0] = addr_va[20:12];
    if (e_lvl[hit_idx][1]) ppn_eff[17:0] = addr_va[29:12];
    hit_pa = {{8{ppn_eff[43]}}, ppn_eff, addr_va[11:0]};
  end

  always_comb begin
    perm_ok = 1'b1;
    if (priv[0] && !e_pte[hit_idx][4]) perm_ok = 1'b0;
    if (priv[1] && e_pte[hit_idx][4] && (!sum || execute)) perm_ok = 1'b0;
    if (read && !(e_pte[hit_idx][1] || (e_pte[hit_idx][3] && mxr))) perm_ok = 1'b0;
    if (write && !e_pte[hit_idx][2]) perm_ok = 1'b0;
    if (execute && !e_pte[hit_idx][3]) perm_ok = 1'b0;
  end

  assign need_wt    = write && (!e_pte[hit_idx][7] || !e_pte[hit_idx][6]);
  assign misaligned = (ptw_level == 2'd1 && ptw_pte[18:10] != 9'd0) ||
                      (ptw_level[1] && ptw_pte[27:10] != 18'd0);

  always_comb begin
    for (int i = 0; i < ENTRIES; i++) begin
      flush_hit[i] = (!flush_va_en || vpn_match(e_vpn[i], flush_vpn, e_lvl[i])) &&
                     (!flush_asid_en || (e_asid[i] == flush_asid && !e_pte[i][5]));
    end
  end

  // ptw_req / wt_req are level requests: raised on entry to WALK / WT and held until
  // the matching ack (or ptw_fault); dropping translation abandons them.
  always_comb begin
    state_d          = state_q;
    addr_pa          = addr_va;
    pte_c            = 1'b0;
    tlb_ready        = 1'b0;
    load_page_fault  = 1'b0;
    store_page_fault = 1'b0;
    ins_page_fault   = 1'b0;
    ptw_req          = 1'b0;
    wt_req           = 1'b0;
    if (!translate) begin
      state_d   = S_IDLE;
      tlb_ready = access;
    end else begin
      if (hit) begin
        addr_pa = hit_pa;
        pte_c   = e_pte[hit_idx][63];
      end
      case (state_q)
        S_IDLE: begin
          if (access) begin
            if (!hit) begin
              state_d = S_WALK;
            end else if (!perm_ok) begin
              load_page_fault  = read;
              store_page_fault = write;
              ins_page_fault   = execute;
            end else if (need_wt) begin
              state_d = S_WT;
            end else begin
              tlb_ready = 1'b1;
            end
          end
        end
        S_WALK: begin
          ptw_req = 1'b1;
          if (ptw_fault) state_d = S_FAULT;
          else if (ptw_ack) state_d = (!(drop || flush) && misaligned) ? S_FAULT : S_IDLE;
        end
        S_WT: begin
          wt_req = 1'b1;
          if (wt_ack) state_d = S_IDLE;
        end
        default: begin
          load_page_fault  = read;
          store_page_fault = write;
          ins_page_fault   = execute;
          state_d          = S_IDLE;
        end
      endcase
    end
  end

  assign wt_pte    = (state_q == S_WT) ? (e_pte[wt_idx] | 64'h00C0) : 64'd0;
  assign wt_pte_pa = (state_q == S_WT) ? e_pte_pa[wt_idx] : 64'd0;

  assign fill_en = translate && state_q == S_WALK && ptw_ack && !ptw_fault &&
                   !drop && !flush && !misaligned;
  assign wt_done = translate && state_q == S_WT && wt_ack && !drop && !flush;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      drop    <= 1'b0;
      rr_ptr  <= '0;
      wt_idx  <= '0;
      e_valid <= '0;
    end else begin
      state_q <= state_d;
      // A flush seen while a walk/write-through is outstanding poisons its completion.
      drop <= ((state_q == S_WALK || state_q == S_WT) && state_d == state_q) ?
              (drop | flush) : 1'b0;
      if (state_q == S_IDLE && state_d == S_WT) wt_idx <= hit_idx;
      if (flush) begin
        for (int i = 0; i < ENTRIES; i++) begin
          if (flush_hit[i]) e_valid[i] <= 1'b0;
        end
      end
      if (fill_en) begin
        e_valid[fill_idx] <= 1'b1;
        if (!free_found) rr_ptr <= rr_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (fill_en) begin
      e_vpn[fill_idx]    <= va_vpn;
      e_asid[fill_idx]   <= asid;
      e_lvl[fill_idx]    <= ptw_level;
      e_ppn[fill_idx]    <= ptw_pte[53:10];
      e_pte[fill_idx]    <= ptw_pte;
      e_pte_pa[fill_idx] <= ptw_pte_pa;
    end
    if (wt_done) e_pte[wt_idx] <= e_pte[wt_idx] | 64'h00C0;
  end

endmodule

// File: tb/tb_tlb_assoc_asid.sv
// Directed bench for tlb_assoc_asid: lookup vector table plus hand-written
// walk / write-through / flush / replacement sequences.
module tb_tlb_assoc_asid;
  localparam int ENTRIES = 8;
  localparam int ASID_W  = 16;
  localparam int NV      = 19;
  localparam logic [3:0] PU = 4'b0001, PS = 4'b0010, PM = 4'b1000;
  localparam logic [2:0] AR = 3'b100, AW = 3'b010, AX = 3'b001, AN = 3'b000;

  logic clk, rst, vm_on, mxr, sum;
  logic [3:0] priv;
  logic [ASID_W-1:0] asid, flush_asid;
  logic read, write, execute;
  logic [63:0] addr_va, addr_pa, ptw_va, ptw_pte, ptw_pte_pa, wt_pte, wt_pte_pa, flush_va;
  logic pte_c, tlb_ready, load_page_fault, store_page_fault, ins_page_fault;
  logic ptw_req, ptw_ack, ptw_fault, wt_req, wt_ack, flush, flush_va_en, flush_asid_en;
  logic [1:0] ptw_level, state_dbg;

  tlb_assoc_asid #(.ENTRIES(ENTRIES), .ASID_W(ASID_W)) dut (
    .clk(clk), .rst(rst), .vm_on(vm_on), .mxr(mxr), .sum(sum), .priv(priv), .asid(asid),
    .read(read), .write(write), .execute(execute), .addr_va(addr_va), .addr_pa(addr_pa),
    .pte_c(pte_c), .tlb_ready(tlb_ready), .load_page_fault(load_page_fault),
    .store_page_fault(store_page_fault), .ins_page_fault(ins_page_fault),
    .ptw_req(ptw_req), .ptw_va(ptw_va), .ptw_ack(ptw_ack), .ptw_fault(ptw_fault),
    .ptw_pte(ptw_pte), .ptw_pte_pa(ptw_pte_pa), .ptw_level(ptw_level),
    .wt_req(wt_req), .wt_pte(wt_pte), .wt_pte_pa(wt_pte_pa), .wt_ack(wt_ack),
    .flush(flush), .flush_va_en(flush_va_en), .flush_asid_en(flush_asid_en),
    .flush_va(flush_va), .flush_asid(flush_asid), .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  typedef struct {
    logic        vm;
    logic [3:0]  pv;
    logic [2:0]  acc;
    logic        sm;
    logic        mx;
    logic [63:0] va;
    logic        rdy;
    logic [2:0]  flt;
    logic        c;
    logic [63:0] pa;
  } vec_t;

  vec_t vecs [NV];
  int n_vec = 0;
  int n_err = 0;

  function automatic vec_t mkv(input logic vm, input logic [3:0] pv, input logic [2:0] acc,
                               input logic sm, input logic mx, input logic [63:0] va,
                               input logic rdy, input logic [2:0] flt, input logic c,
                               input logic [63:0] pa);
    vec_t v;
    v.vm = vm; v.pv = pv; v.acc = acc; v.sm = sm; v.mx = mx; v.va = va;
    v.rdy = rdy; v.flt = flt; v.c = c; v.pa = pa;
    return v;
  endfunction

  function automatic logic [63:0] mk_pte(input logic c, input logic [43:0] ppn,
                                         input logic [9:0] fl);
    return {c, 9'b0, ppn, fl};
  endfunction

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0b expected %0b", nm, act, exp);
    end
  endtask

  task automatic chk64(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic wait_req(input string nm);
    int n;
    n = 0;
    tick();
    while (!ptw_req && n < 4) begin
      tick();
      n++;
    end
    chk1(nm, ptw_req, 1'b1);
  endtask

  task automatic fill(input logic [63:0] va, input logic [63:0] pte, input logic [1:0] lvl,
                      input logic [63:0] ppa, input logic [63:0] exp_pa);
    addr_va = va;
    read    = 1'b1;
    wait_req("fill_req");
    chk64("fill_ptw_va", ptw_va, va);
    ptw_ack = 1'b1; ptw_pte = pte; ptw_level = lvl; ptw_pte_pa = ppa;
    tick();
    ptw_ack = 1'b0;
    #1;
    chk1("fill_hit_ready", tlb_ready, 1'b1);
    chk64("fill_hit_pa", addr_pa, exp_pa);
    read = 1'b0;
  endtask

  task automatic look(input string nm, input logic [63:0] va, input logic exp_rdy);
    tick();
    addr_va = va;
    read    = 1'b1;
    #1;
    chk1(nm, tlb_ready, exp_rdy);
    read = 1'b0;
  endtask

  task automatic flush_all();
    tick();
    flush = 1'b1; flush_va_en = 1'b0; flush_asid_en = 1'b0;
    tick();
    flush = 1'b0;
  endtask

  initial begin
    vecs[0]  = mkv(1, PS, AR, 0, 0, 64'h401234, 1, AN, 0, 64'h80001234);
    vecs[1]  = mkv(1, PS, AW, 0, 0, 64'h401234, 0, AW, 0, 64'h80001234);
    vecs[2]  = mkv(1, PS, AX, 0, 0, 64'h401234, 0, AX, 0, 64'h80001234);
    vecs[3]  = mkv(1, PS, AR, 0, 0, 64'h3FF010, 1, AN, 1, 64'h803FF010);
    vecs[4]  = mkv(1, PS, AR, 0, 0, 64'h200ABC, 1, AN, 1, 64'h80200ABC);
    vecs[5]  = mkv(1, PS, AW, 0, 0, 64'h3FF010, 1, AN, 1, 64'h803FF010);
    vecs[6]  = mkv(1, PU, AX, 0, 0, 64'h5004,   1, AN, 0, 64'h12345004);
    vecs[7]  = mkv(1, PS, AR, 0, 0, 64'h5004,   0, AR, 0, 64'h12345004);
    vecs[8]  = mkv(1, PS, AR, 1, 0, 64'h5004,   1, AN, 0, 64'h12345004);
    vecs[9]  = mkv(1, PS, AX, 1, 0, 64'h5004,   0, AX, 0, 64'h12345004);
    vecs[10] = mkv(1, PU, AR, 0, 0, 64'h401234, 0, AR, 0, 64'h80001234);
    vecs[11] = mkv(1, PS, AR, 0, 0, 64'h6008,   0, AR, 0, 64'h777008);
    vecs[12] = mkv(1, PS, AR, 0, 1, 64'h6008,   1, AN, 0, 64'h777008);
    vecs[13] = mkv(1, PU, AX, 0, 0, 64'h6008,   0, AX, 0, 64'h777008);
    vecs[14] = mkv(1, PS, AX, 0, 0, 64'h6008,   1, AN, 0, 64'h777008);
    vecs[15] = mkv(1, PS, AR, 0, 0, 64'h90AB,   1, AN, 0, 64'hFF800000000010AB);
    vecs[16] = mkv(0, PS, AR, 0, 0, 64'hDEADBEEF, 1, AN, 0, 64'hDEADBEEF);
    vecs[17] = mkv(1, PM, AW, 0, 0, 64'h1234,   1, AN, 0, 64'h1234);
    vecs[18] = mkv(1, PS, AR, 0, 0, 64'h8000,   0, AN, 0, 64'h8000);

    rst = 1'b0; vm_on = 1'b1; mxr = 1'b0; sum = 1'b0; priv = PS; asid = 16'd1;
    read = 1'b1; write = 1'b0; execute = 1'b0; addr_va = 64'h12345678;
    ptw_ack = 1'b0; ptw_fault = 1'b0; ptw_pte = '0; ptw_pte_pa = '0; ptw_level = '0;
    wt_ack = 1'b0; flush = 1'b0; flush_va_en = 1'b0; flush_asid_en = 1'b0;
    flush_va = '0; flush_asid = '0;
    #2;
    chk64("rst_addr_pa", addr_pa, 64'h12345678);
    chk1("rst_ready", tlb_ready, 1'b0);
    chk1("rst_ptw_req", ptw_req, 1'b0);
    chk1("rst_wt_req", wt_req, 1'b0);
    chk1("rst_lpf", load_page_fault, 1'b0);
    chk64("rst_state", {62'b0, state_dbg}, 64'd0);
    read = 1'b0;
    #20 rst = 1'b1;

    // populate: sum/mxr high so the post-fill read check passes on U and X-only pages
    sum = 1'b1; mxr = 1'b1;
    fill(64'h401234, mk_pte(0, 44'h80001, 10'h043), 2'd0, 64'h10000000, 64'h80001234);
    fill(64'h3FF010, mk_pte(1, 44'h80200, 10'h0C7), 2'd1, 64'h10000008, 64'h803FF010);
    fill(64'h5004,   mk_pte(0, 44'h12345, 10'h0DF), 2'd0, 64'h10000010, 64'h12345004);
    fill(64'h6008,   mk_pte(0, 44'h00777, 10'h049), 2'd0, 64'h10000018, 64'h777008);
    fill(64'h7000,   mk_pte(0, 44'h00888, 10'h047), 2'd0, 64'h10000038, 64'h888000);
    fill(64'h90AB,   mk_pte(0, 44'h80000000001, 10'h043), 2'd0, 64'h10000040,
         64'hFF800000000010AB);

    for (int i = 0; i < NV; i++) begin
      tick();
      vm_on = vecs[i].vm; priv = vecs[i].pv; {read, write, execute} = vecs[i].acc;
      sum = vecs[i].sm; mxr = vecs[i].mx; addr_va = vecs[i].va;
      #1;
      chk1($sformatf("v%0d_ready", i), tlb_ready, vecs[i].rdy);
      chk1($sformatf("v%0d_lpf", i), load_page_fault, vecs[i].flt[2]);
      chk1($sformatf("v%0d_spf", i), store_page_fault, vecs[i].flt[1]);
      chk1($sformatf("v%0d_ipf", i), ins_page_fault, vecs[i].flt[0]);
      chk1($sformatf("v%0d_ptw_req", i), ptw_req, 1'b0);
      chk1($sformatf("v%0d_pte_c", i), pte_c, vecs[i].c);
      chk64($sformatf("v%0d_pa", i), addr_pa, vecs[i].pa);
      {read, write, execute} = AN;
    end
    vm_on = 1'b1; priv = PS; sum = 1'b1; mxr = 1'b1;

    // dirty-bit write-through
    tick();
    write = 1'b1; addr_va = 64'h7000;
    #1;
    chk1("wt_first_ready", tlb_ready, 1'b0);
    tick();
    chk1("wt_req", wt_req, 1'b1);
    chk64("wt_pte", wt_pte, mk_pte(0, 44'h00888, 10'h0C7));
    chk64("wt_pte_pa", wt_pte_pa, 64'h10000038);
    chk1("wt_wait_ready", tlb_ready, 1'b0);
    wt_ack = 1'b1;
    tick();
    wt_ack = 1'b0;
    #1;
    chk1("wt_done_ready", tlb_ready, 1'b1);
    chk1("wt_done_req", wt_req, 1'b0);
    tick();
    chk1("wt_no_repeat", wt_req, 1'b0);
    write = 1'b0;

    // misaligned 2M leaf -> one-cycle load fault
    addr_va = 64'hA00000; read = 1'b1;
    wait_req("mis_req");
    ptw_ack = 1'b1; ptw_level = 2'd1; ptw_pte = mk_pte(0, 44'h80201, 10'h0C7);
    tick();
    ptw_ack = 1'b0;
    chk1("mis_lpf", load_page_fault, 1'b1);
    chk1("mis_ready", tlb_ready, 1'b0);
    read = 1'b0;
    tick();
    chk1("mis_lpf_clear", load_page_fault, 1'b0);
    chk1("mis_req_clear", ptw_req, 1'b0);

    // walker fault on a store
    addr_va = 64'hB000; write = 1'b1;
    wait_req("pf_req");
    ptw_fault = 1'b1;
    tick();
    ptw_fault = 1'b0;
    chk1("pf_spf", store_page_fault, 1'b1);
    write = 1'b0;
    tick();
    chk1("pf_spf_clear", store_page_fault, 1'b0);

    // flush by VA inside a 2M superpage
    tick();
    flush = 1'b1; flush_va_en = 1'b1; flush_va = 64'h200000;
    tick();
    flush = 1'b0; flush_va_en = 1'b0;
    look("fva_super_gone", 64'h3FF010, 1'b0);
    look("fva_other_kept", 64'h401234, 1'b1);

    // vm_on falling mid-walk
    addr_va = 64'hC000; read = 1'b1;
    wait_req("vmf_req");
    vm_on = 1'b0;
    #1;
    chk1("vmf_req_drop", ptw_req, 1'b0);
    tick();
    vm_on = 1'b1; read = 1'b0;
    #1;
    chk1("vmf_idle_req", ptw_req, 1'b0);
    chk64("vmf_state", {62'b0, state_dbg}, 64'd0);

    // round-robin replacement
    flush_all();
    for (int i = 0; i < ENTRIES + 2; i++) begin
      fill(64'h100000 + (64'(i) << 12), mk_pte(0, 44'h100 + 44'(i), 10'h043), 2'd0,
           64'h20000000 + 64'(i * 8), 64'h100000 + (64'(i) << 12));
    end
    for (int i = 0; i < ENTRIES + 2; i++) begin
      look($sformatf("rr_page%0d", i), 64'h100000 + (64'(i) << 12), i >= 2);
    end

    // ASID tagging and ASID-selective flush
    flush_all();
    asid = 16'd1;
    fill(64'h300000, mk_pte(0, 44'h300, 10'h043), 2'd0, 64'h30000000, 64'h300000);
    asid = 16'd2;
    fill(64'h301000, mk_pte(0, 44'h301, 10'h043), 2'd0, 64'h30000008, 64'h301000);
    fill(64'h302000, mk_pte(0, 44'h302, 10'h063), 2'd0, 64'h30000010, 64'h302000);
    look("asid_mismatch", 64'h300000, 1'b0);
    tick();
    flush = 1'b1; flush_asid_en = 1'b1; flush_asid = 16'd1;
    tick();
    flush = 1'b0; flush_asid_en = 1'b0;
    asid = 16'd1;
    look("fas_a_gone", 64'h300000, 1'b0);
    look("fas_g_kept", 64'h302000, 1'b1);
    asid = 16'd2;
    look("fas_b_kept", 64'h301000, 1'b1);

    // flush in the ptw_ack cycle discards the fill and forces a re-walk
    addr_va = 64'h303000; read = 1'b1;
    wait_req("fia_req");
    ptw_ack = 1'b1; ptw_level = 2'd0; ptw_pte = mk_pte(0, 44'h303, 10'h043);
    flush = 1'b1; flush_va_en = 1'b1; flush_va = 64'hDEAD000;
    tick();
    ptw_ack = 1'b0; flush = 1'b0; flush_va_en = 1'b0;
    chk1("fia_discard", tlb_ready, 1'b0);
    wait_req("fia_rewalk");
    ptw_ack = 1'b1;
    tick();
    ptw_ack = 1'b0;
    #1;
    chk1("fia_refill_ready", tlb_ready, 1'b1);
    chk64("fia_refill_pa", addr_pa, 64'h303000);
    read = 1'b0;
    look("fia_b_kept", 64'h301000, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
